// File: rtl/ref_block_loader_pkg.sv
// Shared constants and state encoding for the reference block loader.
// The same geometry and FSM encoding are reused by the interpolation top level.
// No logic; parameters, types and encodings only.
package ref_block_loader_pkg;

    localparam int PIX_W   = 8;
    localparam int BLK_DIM = 15;                  // 8 outputs + 7 filter taps
    localparam int ROW_W   = PIX_W * BLK_DIM;     // 120 bits per row beat
    localparam int BUF_W   = ROW_W * BLK_DIM;     // 1800 bits per window
    localparam int CNT_W   = 4;                   // row index 0..14

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(BLK_DIM - 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_FULL = 2'd1,
        ST_DROP = 2'd2
    } state_e;

endpackage

// File: rtl/ref_block_loader_row_bank.sv
// Purpose: 15 x 120-bit row store, written one row at a time, read flat.
// Latency: write visible on rd_dat the cycle after wr_en; read is combinational.
// Backpressure: none; the owner decides when a write is allowed.
// Ports: clk, rst (async active-low), wr_en/wr_idx/wr_dat row write,
//        rd_dat flat window (row r at [r*ROW_W +: ROW_W]).
module ref_block_loader_row_bank
    import ref_block_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_idx,
    input  logic [ROW_W-1:0] wr_dat,
    output logic [BUF_W-1:0] rd_dat
);

    logic [ROW_W-1:0] mem_q [BLK_DIM];
    logic [ROW_W-1:0] mem_d [BLK_DIM];

    always_comb begin
        for (int r = 0; r < BLK_DIM; r++) begin
            mem_d[r] = mem_q[r];
        end
        if (wr_en) begin
            mem_d[wr_idx] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < BLK_DIM; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < BLK_DIM; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    for (genvar g = 0; g < BLK_DIM; g++) begin : g_rd
        assign rd_dat[g*ROW_W +: ROW_W] = mem_q[g];
    end

endmodule

// File: rtl/ref_block_loader.sv
// Purpose: gathers 15 row beats into a 15x15 8-bit window, checks row framing, drops bad blocks.
// Latency: blk_valid rises 1 cycle after the handshake of the final (row_last) row.
// Backpressure: row_ready drops while no bank is free; blk_valid holds until blk_ready.
// Ports: clk, rst (async active-low); row_valid/row_ready/row_data/row_last row stream in;
//        blk_valid/blk_ready/in_buffer window out; blk_err one-cycle framing-error pulse.
// Build option: DOUBLE_BUF_EN selects two ping-pong banks (fill one while the other is published).
module ref_block_loader
    import ref_block_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [ROW_W-1:0] row_data,
    input  logic             row_last,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [BUF_W-1:0] in_buffer,
    output logic             blk_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic             row_ready_q, row_ready_d;
    logic             blk_valid_q, blk_valid_d;
    logic             blk_err_q, blk_err_d;
    logic             bank_wr;

    wire accept  = row_valid && row_ready_q;
    wire consume = blk_valid_q && blk_ready;

`ifdef DOUBLE_BUF_EN
    // wr_bank is being filled, rd_bank is the oldest complete bank.
    // When both banks are full they point at the same bank (the older one).
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;
`endif

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        blk_err_d = 1'b0;
        bank_wr   = 1'b0;
`ifdef DOUBLE_BUF_EN
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        if (consume) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
`endif

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    bank_wr = 1'b1;
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d = '0;
                        if (row_last) begin
`ifdef DOUBLE_BUF_EN
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = ~wr_bank_q;
                            // Stall only if the next bank is still awaiting its consumer.
                            if (full_d[wr_bank_d]) begin
                                state_d = ST_FULL;
                            end
`else
                            state_d = ST_FULL;
`endif
                        end else begin
                            blk_err_d = 1'b1;
                            state_d   = ST_DROP;
                        end
                    end else if (row_last) begin
                        // Early last: discard the partial block, next beat is row 0.
                        blk_err_d = 1'b1;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DROP: begin
                if (accept && row_last) begin
                    state_d   = ST_FILL;
                    row_cnt_d = '0;
                end
            end
            ST_FULL: begin
                // A consume always frees the bank that wr_bank points at.
                if (consume) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d   = ST_FILL;
                row_cnt_d = '0;
            end
        endcase

        row_ready_d = (state_d != ST_FULL);
`ifdef DOUBLE_BUF_EN
        blk_valid_d = full_d[rd_bank_d];
`else
        blk_valid_d = (state_d == ST_FULL);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FILL;
            row_cnt_q   <= '0;
            row_ready_q <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_err_q   <= 1'b0;
`ifdef DOUBLE_BUF_EN
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            row_ready_q <= row_ready_d;
            blk_valid_q <= blk_valid_d;
            blk_err_q   <= blk_err_d;
`ifdef DOUBLE_BUF_EN
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
`endif
        end
    end

`ifdef DOUBLE_BUF_EN
    logic [BUF_W-1:0] rd_dat0, rd_dat1;

    ref_block_loader_row_bank u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (bank_wr && !wr_bank_q),
        .wr_idx (row_cnt_q),
        .wr_dat (row_data),
        .rd_dat (rd_dat0)
    );

    ref_block_loader_row_bank u_bank1 (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (bank_wr && wr_bank_q),
        .wr_idx (row_cnt_q),
        .wr_dat (row_data),
        .rd_dat (rd_dat1)
    );

    assign in_buffer = rd_bank_q ? rd_dat1 : rd_dat0;
`else
    ref_block_loader_row_bank u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (bank_wr),
        .wr_idx (row_cnt_q),
        .wr_dat (row_data),
        .rd_dat (in_buffer)
    );
`endif

    assign row_ready = row_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_err   = blk_err_q;

endmodule

// File: tb/tb_ref_block_loader.sv
// Directed bench for ref_block_loader: per-cycle stimulus table with expected outputs,
// plus hand-written reset sequences (and a streaming sequence for the double-bank build).
module tb_ref_block_loader;
    import ref_block_loader_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             row_valid = 1'b0;
    logic             row_ready;
    logic [ROW_W-1:0] row_data = '0;
    logic             row_last = 1'b0;
    logic             blk_valid;
    logic             blk_ready = 1'b0;
    logic [BUF_W-1:0] in_buffer;
    logic             blk_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ref_block_loader dut (
        .clk       (clk),
        .rst       (rst),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_last  (row_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .in_buffer (in_buffer),
        .blk_err   (blk_err)
    );

    typedef struct {
        logic       vld;
        logic       last;
        logic [7:0] val;
        logic       rdy;
        logic       e_rrdy;
        logic       e_bvld;
        logic       e_err;
        logic       chk_buf;
        logic [7:0] base;
    } step_t;

    step_t steps[$];

    function automatic logic [BUF_W-1:0] pat(input logic [7:0] base);
        logic [BUF_W-1:0] p;
        p = '0;
        for (int r = 0; r < BLK_DIM; r++) begin
            for (int c = 0; c < BLK_DIM; c++) begin
                p[r*ROW_W + c*PIX_W +: PIX_W] = 8'(base + 8'(r));
            end
        end
        return p;
    endfunction

    task automatic push(input logic vld, input logic last, input logic [7:0] val, input logic rdy,
                        input logic e_rrdy, input logic e_bvld, input logic e_err,
                        input logic chk_buf, input logic [7:0] base);
        step_t s;
        s.vld = vld; s.last = last; s.val = val; s.rdy = rdy;
        s.e_rrdy = e_rrdy; s.e_bvld = e_bvld; s.e_err = e_err;
        s.chk_buf = chk_buf; s.base = base;
        steps.push_back(s);
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [BUF_W-1:0] exp);
        checks++;
        if (in_buffer !== exp) begin
            errors++;
            for (int r = 0; r < BLK_DIM; r++) begin
                if (in_buffer[r*ROW_W +: ROW_W] !== exp[r*ROW_W +: ROW_W]) begin
                    $display("FAIL %s: row %0d got %h expected %h at %0t", nm, r,
                             in_buffer[r*ROW_W +: ROW_W], exp[r*ROW_W +: ROW_W], $time);
                    break;
                end
            end
        end
    endtask

    task automatic drive(input logic vld, input logic last, input logic [7:0] val, input logic rdy);
        row_valid = vld;
        row_last  = last;
        row_data  = {BLK_DIM{val}};
        blk_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_bit("rst_row_ready", row_ready, 1'b0);
        chk_bit("rst_blk_valid", blk_valid, 1'b0);
        chk_bit("rst_blk_err", blk_err, 1'b0);
        chk_vec("rst_in_buffer", '0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        chk_bit("post_rst_row_ready", row_ready, 1'b1);

`ifndef DOUBLE_BUF_EN
        // Clean block, row r = r
        for (int r = 0; r < 15; r++) push(1'b1, r == 14, 8'(r), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // Consumer stalls 20 cycles while upstream keeps offering rows
        for (int i = 0; i < 20; i++) push(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        push(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        push(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // Early last on row 5, then a clean block (error pulse lands on its first beat)
        for (int r = 0; r < 6; r++) push(1'b1, r == 5, 8'(8'h50 + r), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int r = 0; r < 15; r++) push(1'b1, r == 14, 8'(8'h20 + r), 1'b0, 1'b1, 1'b0, r == 0, 1'b0, 8'h00);
        push(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
        push(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // Missing last, three junk beats (last on third), then a clean block
        for (int r = 0; r < 15; r++) push(1'b1, 1'b0, 8'(8'h70 + r), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 3; j++) push(1'b1, j == 2, 8'hAA, 1'b0, 1'b1, 1'b0, j == 0, 1'b0, 8'h00);
        for (int r = 0; r < 15; r++) push(1'b1, r == 14, 8'(8'h30 + r), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        push(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30);
        push(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        for (int k = 0; k < steps.size(); k++) begin
            drive(steps[k].vld, steps[k].last, steps[k].val, steps[k].rdy);
            @(negedge clk);
            chk_bit($sformatf("step%0d_row_ready", k), row_ready, steps[k].e_rrdy);
            chk_bit($sformatf("step%0d_blk_valid", k), blk_valid, steps[k].e_bvld);
            chk_bit($sformatf("step%0d_blk_err", k), blk_err, steps[k].e_err);
            if (steps[k].chk_buf) chk_vec($sformatf("step%0d_in_buffer", k), pat(steps[k].base));
            next_cycle();
        end

        // Reset asserted during row 9
        for (int r = 0; r < 10; r++) begin
            drive(1'b1, 1'b0, 8'(8'h60 + r), 1'b0);
            if (r < 9) next_cycle();
        end
        #2 rst = 1'b0;
        #1;
        chk_bit("midrst_blk_valid", blk_valid, 1'b0);
        chk_bit("midrst_row_ready", row_ready, 1'b0);
        chk_bit("midrst_blk_err", blk_err, 1'b0);
        chk_vec("midrst_in_buffer", '0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        chk_bit("midrst_rel_row_ready", row_ready, 1'b1);

        // A full fresh block is needed before publish
        for (int r = 0; r < 15; r++) begin
            drive(1'b1, r == 14, 8'(8'h40 + r), 1'b0);
            @(negedge clk);
            chk_bit($sformatf("fresh%0d_blk_valid", r), blk_valid, 1'b0);
            chk_bit($sformatf("fresh%0d_blk_err", r), blk_err, 1'b0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk_bit("fresh_pub_blk_valid", blk_valid, 1'b1);
        chk_vec("fresh_pub_in_buffer", pat(8'h40));

        // Reset while a block is published clears blk_valid at once
        #1 rst = 1'b0;
        #1;
        chk_bit("pubrst_blk_valid", blk_valid, 1'b0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
`else
        begin
            int nblk;
            nblk = 0;
            for (int i = 0; i < 52; i++) begin
                if (i < 45) drive(1'b1, (i % 15) == 14, 8'((i / 15) * 16 + (i % 15)), 1'b1);
                else drive(1'b0, 1'b0, 8'h00, 1'b1);
                @(negedge clk);
                if (i < 45) chk_bit($sformatf("db%0d_row_ready", i), row_ready, 1'b1);
                if (blk_valid) begin
                    chk_vec($sformatf("db_blk%0d_in_buffer", nblk), pat(8'(nblk * 16)));
                    nblk++;
                end
                next_cycle();
            end
            checks++;
            if (nblk != 3) begin
                errors++;
                $display("FAIL db_block_count: got %0d expected 3", nblk);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
